// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job scheduler: operand/accumulator widths and
// the scheduler state encoding.
package mac_pkg;

    localparam int MAC_OP_W  = 16;
    localparam int MAC_ACC_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } mac_sched_state_t;

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Requester beat streams and job response handshake of the MAC job scheduler.
interface mac_job_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int LEN_W = 16
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]    req_last;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic [LEN_W-1:0]   rsp_len;

    modport slave (
        input  req_valid, req_a, req_b, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_len
    );

    modport master (
        output req_valid, req_a, req_b, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_len
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr+1,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin : scan
            int unsigned idx;
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// Shares one external MAC between NREQ requesters: round-robin job grant, beat
// streaming, pipeline drain and per-job result isolation by base subtraction.
module mac_job_scheduler
    import mac_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_job_scheduler_if.slave   bus,
    output logic [MAC_OP_W-1:0]  mac_a,
    output logic [MAC_OP_W-1:0]  mac_b,
    output logic                 mac_valid_in,
    input  logic [MAC_ACC_W-1:0] mac_result,
    input  logic                 mac_valid_out,
    output logic                 busy
);

    localparam int IDW = $clog2(NREQ);

    mac_sched_state_t     state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d, grant_idx, rsp_id_q, rsp_id_d;
    logic [NREQ-1:0]      grant, sel_onehot;
    logic [LEN_W-1:0]     len_q, len_d, rsp_len_q, rsp_len_d;
    logic [2:0]           out_q, out_d, out_step;
    logic [MAC_ACC_W-1:0] base_q, base_d, rsp_data_q, rsp_data_d;
    logic [MAC_OP_W-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d, sel_a, sel_b;
    logic                 mac_v_q, sel_valid, sel_last, beat, dec;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        sel_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ptr_q == IDW'(i)) begin
                sel_valid     = bus.req_valid[i];
                sel_last      = bus.req_last[i];
                sel_a         = bus.req_a[i*MAC_OP_W +: MAC_OP_W];
                sel_b         = bus.req_b[i*MAC_OP_W +: MAC_OP_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign beat = (state_q == STREAM) && sel_valid;
    // Results for early beats can return while later beats are still streaming.
    assign dec  = mac_valid_out && ((state_q == STREAM) || (state_q == DRAIN));
    assign out_step = out_q + {2'b00, beat} - {2'b00, dec};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        out_d      = out_step;
        base_d     = base_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_len_d  = rsp_len_q;
        mac_a_d    = beat ? sel_a : mac_a_q;
        mac_b_d    = beat ? sel_b : mac_b_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    ptr_d   = grant_idx;
                    len_d   = '0;
                    out_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat) begin
                    len_d = len_q + 1'b1;
                    if (sel_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_step == 3'd0) begin
                    rsp_data_d = mac_result - base_q;
                    base_d     = mac_result;
                    rsp_id_d   = ptr_q;
                    rsp_len_d  = len_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NREQ - 1);
            len_q      <= '0;
            out_q      <= '0;
            base_q     <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_len_q  <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            mac_v_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            out_q      <= out_d;
            base_q     <= base_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_len_q  <= rsp_len_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            mac_v_q    <= beat;
        end
    end

    assign bus.req_ready = (state_q == STREAM) ? sel_onehot : '0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_len   = rsp_len_q;
    assign mac_a         = mac_a_q;
    assign mac_b         = mac_b_q;
    assign mac_valid_in  = mac_v_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler with a behavioural two-stage MAC model.
module tb_mac_job_scheduler;

    localparam int NREQ  = 2;
    localparam int LEN_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mac_a, mac_b;
    logic        mac_valid_in, mac_valid_out, busy;
    logic [31:0] mac_result;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;

    mac_job_scheduler_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    mac_job_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_result    (mac_result),
        .mac_valid_out (mac_valid_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC: product registered one edge after the beat, accumulated the edge after.
    logic [31:0] prod_q, acc_q;
    logic        pv_q, vo_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0; pv_q <= 1'b0; acc_q <= '0; vo_q <= 1'b0;
        end else begin
            prod_q <= 32'(mac_a) * 32'(mac_b);
            pv_q   <= mac_valid_in;
            if (pv_q) acc_q <= acc_q + prod_q;
            vo_q   <= pv_q;
        end
    end
    assign mac_result    = acc_q;
    assign mac_valid_out = vo_q;

    typedef struct {
        int               id;
        int               n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [31:0]      data;
        logic [15:0]      len;
    } job_t;

    job_t vec[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic last, output int acc_c);
        bit done = 0;
        bus.req_valid[id]       = 1'b1;
        bus.req_a[16*id +: 16]  = a;
        bus.req_b[16*id +: 16]  = b;
        bus.req_last[id]        = last;
        acc_c = cyc;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.req_ready[id]) done = 1;
            tick();
        end
        acc_c = cyc;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic send_job(input int id, input int n, input logic [3:0][15:0] a,
                            input logic [3:0][15:0] b, output int first_c, output int last_c);
        int c;
        first_c = 0;
        last_c  = 0;
        for (int k = 0; k < n; k++) begin
            send_beat(id, a[k], b[k], (k == n - 1), c);
            if (k == 0) first_c = c;
            last_c = c;
        end
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_c);
        bit done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            if (bus.rsp_valid) done = 1;
            else tick();
        end
        rsp_c = cyc;
        if (!done) check("rsp_timeout", 0, 1);
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // Both requesters present a single-beat job at once; responses logged in order.
    task automatic serve_both(output int id0, output int d0, output int id1, output int d1);
        int ids[2];
        int ds[2];
        int nr = 0;
        logic [1:0] acc;
        bit hs;
        ids = '{-1, -1};
        ds  = '{0, 0};
        bus.req_a = {16'd2, 16'd1};
        bus.req_b = {16'd3, 16'd1};
        bus.req_last  = 2'b11;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 40 && nr < 2; k++) begin
            hs = 0;
            if (bus.rsp_valid) begin
                ids[nr] = int'(bus.rsp_id);
                ds[nr]  = int'(bus.rsp_data);
                nr++;
                bus.rsp_ready = 1'b1;
                hs = 1;
            end
            acc = bus.req_valid & bus.req_ready;
            tick();
            bus.req_valid = bus.req_valid & ~acc;
            bus.req_last  = bus.req_last & ~acc;
            if (hs) bus.rsp_ready = 1'b0;
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        if (nr < 2) check("serve_both_timeout", 0, 1);
        id0 = ids[0]; d0 = ds[0]; id1 = ids[1]; d1 = ds[1];
    endtask

    function automatic job_t mk(input int id, input int n,
                                input logic [15:0] a0, a1, a2, a3,
                                input logic [15:0] b0, b1, b2, b3,
                                input logic [31:0] data);
        job_t j;
        j.id = id; j.n = n;
        j.a = {a3, a2, a1, a0};
        j.b = {b3, b2, b1, b0};
        j.data = data;
        j.len = 16'(n);
        return j;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f, l, rc, i0, d0, i1, d1, hits;

        vec[0] = mk(0, 2, 16'd3, 16'd4, 0, 0, 16'd5, 16'd6, 0, 0, 32'd39);
        vec[1] = mk(0, 2, 16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFC0002);
        vec[2] = mk(1, 1, 16'd2, 0, 0, 0, 16'd7, 0, 0, 0, 32'd14);
        vec[3] = mk(1, 3, 16'd1, 16'd2, 16'd3, 0, 16'd4, 16'd5, 16'd6, 0, 32'd32);
        vec[4] = mk(0, 4, 16'd1, 16'd1, 16'd1, 16'd1, 16'd10, 16'd20, 16'd30, 16'd40, 32'd100);

        bus.req_valid = '0; bus.req_last = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        tick(); tick();
        check("reset_ctrl", {busy, bus.req_ready, mac_valid_in, bus.rsp_valid, bus.rsp_id,
                             bus.rsp_len}, 64'd0);
        check("reset_data", {mac_a, mac_b, bus.rsp_data}, 64'd0);

        // Simultaneous requests straight out of reset, two rounds.
        reset = 1'b0;
        serve_both(i0, d0, i1, d1);
        check("rr1_first_id", 64'(i0), 64'd0);
        check("rr1_first_data", 64'(d0), 64'd1);
        check("rr1_second_id", 64'(i1), 64'd1);
        check("rr1_second_data", 64'(d1), 64'd6);
        tick();
        serve_both(i0, d0, i1, d1);
        check("rr2_first_id", 64'(i0), 64'd0);
        check("rr2_second_id", 64'(i1), 64'd1);
        check("rr2_second_data", 64'(d1), 64'd6);

        for (int v = 0; v < 5; v++) begin
            send_job(vec[v].id, vec[v].n, vec[v].a, vec[v].b, f, l);
            check($sformatf("v%0d_throughput", v), 64'(l - f), 64'(vec[v].n - 1));
            wait_rsp(rc);
            check($sformatf("v%0d_latency", v), 64'(rc - l), 64'd3);
            check($sformatf("v%0d_data", v), 64'(bus.rsp_data), 64'(vec[v].data));
            check($sformatf("v%0d_id", v), 64'(bus.rsp_id), 64'(vec[v].id));
            check($sformatf("v%0d_len", v), 64'(bus.rsp_len), 64'(vec[v].len));
            handshake();
        end

        // Response back-pressure with another requester waiting.
        send_job(0, 1, {48'd0, 16'd9}, {48'd0, 16'd9}, f, l);
        wait_rsp(rc);
        bus.req_a[31:16] = 16'd2; bus.req_b[31:16] = 16'd2;
        bus.req_last[1] = 1'b1; bus.req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_c%0d", k),
                  {bus.rsp_valid, bus.rsp_data, bus.req_ready, mac_valid_in},
                  {1'b1, 32'd81, 2'b00, 1'b0});
            tick();
        end
        handshake();
        check("gap_idle", {busy, bus.req_ready}, 64'd0);
        tick();
        check("gap_grant", {busy, bus.req_ready}, {1'b1, 2'b10});
        send_beat(1, 16'd2, 16'd2, 1'b1, l);
        bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0;
        wait_rsp(rc);
        check("after_stall_latency", 64'(rc - l), 64'd3);
        check("after_stall_data", {bus.rsp_id, bus.rsp_data}, {1'b1, 32'd4});
        handshake();

        // Reset in the middle of a 4-beat job.
        tick();
        send_beat(0, 16'd1, 16'd1, 1'b0, l);
        send_beat(0, 16'd2, 16'd2, 1'b0, l);
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        #1;
        check("midreset_ctrl", {busy, bus.req_ready, mac_valid_in, bus.rsp_valid, bus.rsp_id,
                                bus.rsp_len}, 64'd0);
        check("midreset_data", {mac_a, mac_b, bus.rsp_data}, 64'd0);
        tick();
        reset = 1'b0;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.rsp_valid) hits++;
            tick();
        end
        check("no_rsp_after_reset", 64'(hits), 64'd0);
        send_job(0, 1, {48'd0, 16'd5}, {48'd0, 16'd5}, f, l);
        wait_rsp(rc);
        check("post_reset_data", 64'(bus.rsp_data), 64'd25);
        check("post_reset_id_len", {bus.rsp_id, bus.rsp_len}, {1'b0, 16'd1});
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mac_job_scheduler.md
# mac_job_scheduler

Sequences and shares one `mac_unit` multiply-accumulate datapath between NREQ operand-stream requesters. Each requester submits a job: a burst of 16-bit operand pairs terminated by a `last` flag. The scheduler grants jobs round-robin, feeds the beats into the MAC, and waits for the pipeline to drain. It then returns the job's dot product on a response handshake. The MAC accumulator has no clear input, so per-job isolation is done by subtracting a tracked base value.

## Interface
- NREQ, 2: number of requesters (2..4).
- LEN_W, 16: width of the per-job beat counter `rsp_len`.
- IDW, $clog2(NREQ): localparam, requester index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_ready  out  NREQ  per-requester beat accept
- req_a  in  NREQ*16  operand A, requester i at bits [16i+15:16i]
- req_b  in  NREQ*16  operand B, same packing as req_a
- req_last  in  NREQ  beat is the final beat of the job
- mac_a  out  16  operand A to MAC (registered)
- mac_b  out  16  operand B to MAC (registered)
- mac_valid_in  out  1  beat valid to MAC (registered)
- mac_result  in  32  MAC accumulator value
- mac_valid_out  in  1  MAC accumulator updated
- rsp_valid  out  1  job result available
- rsp_ready  in  1  result consumed
- rsp_data  out  32  job dot product, modulo 2^32
- rsp_id  out  IDW  index of the requester that owned the job
- rsp_len  out  LEN_W  beats in the job, modulo 2^LEN_W
- busy  out  1  state is not IDLE

## Operation
The scheduler is a four-state machine: IDLE, STREAM, DRAIN, RESP.

- **IDLE**
  - All `req_ready` outputs are 0.
  - If any `req_valid` is set, grant the first requesting index at or after `ptr+1`, wrapping modulo NREQ.
  - On grant: `ptr <= grant`, clear `len` and `outstanding`, go to STREAM.
- **STREAM**
  - `req_ready[g] = 1` for the granted requester only.
  - On each `req_valid[g] & req_ready[g]`:
    - register `req_a[g]` and `req_b[g]` into `mac_a`/`mac_b`, and drive `mac_valid_in = 1` in the next cycle;
    - `len++`, `outstanding++`.
  - If the beat has `req_last` set, go to DRAIN.
  - `mac_valid_in` is 0 in any cycle that follows no accepted beat.
- **DRAIN**
  - `outstanding--` on each cycle in which `mac_valid_out` is sampled high.
  - The increment and the decrement apply in the same cycle when both events occur.
  - When `outstanding` would reach 0 this cycle, go to RESP.
  - On that transition:
    - `rsp_data <= mac_result - base`, modulo 2^32;
    - `base <= mac_result`;
    - latch `rsp_id` and `rsp_len`.
- **RESP**
  - `rsp_valid = 1`, with data, id and length held stable.
  - On `rsp_ready`, go to IDLE.
  - No grant is made in the same cycle; the next grant is at the earliest one cycle after the response handshake.

Other rules:
- The requester grant is held for the whole job; other requesters are not served mid-job.
- `outstanding` is a 3-bit counter; its maximum in flight is 3.
- `mac_valid_out` in IDLE or RESP is a protocol error and is ignored.
- `len` wraps modulo 2^LEN_W.

Reset values:
- State IDLE; `ptr = NREQ-1`, so requester 0 has first priority.
- `base`, `len`, `outstanding` = 0.
- All outputs 0.
- The MAC shares `reset`, so `base = 0` matches the MAC accumulator.
- Reset mid-job aborts the job silently and produces no response.

## Timing
- Beat accepted at edge E0:
  - `mac_valid_in` is high during E0..E1;
  - the MAC registers the product at E1;
  - `mac_valid_out` is high during E2..E3.
- Last beat accepted at E0 → `rsp_valid` rises after E3. Latency is 3 cycles from last-beat accept.
- Back-to-back jobs: at least 1 idle cycle between the response handshake and the next grant, plus 1 grant cycle before the first beat is accepted.
- Streaming throughput: 1 beat per cycle when `req_valid` is held high.

## Structure
- **Shared package `mac_pkg`**:
  - `MAC_OP_W = 16`, `MAC_ACC_W = 32`;
  - state enum `mac_sched_state_t` {IDLE, STREAM, DRAIN, RESP}.
- **Sub-module `rr_arbiter`**:
  - parameter NREQ;
  - inputs `req` and `ptr`;
  - outputs one-hot `grant` and the encoded grant index;
  - purely combinational.
- The scheduler instantiates `rr_arbiter` and connects to an external `mac_unit` at the level above.

## Test plan
- After reset, req0 sends a=[3,4], b=[5,6] → `rsp_data` = 39, `rsp_id` = 0, `rsp_len` = 2; `rsp_valid` rises 3 cycles after the last beat is accepted.
- Then req1 sends a=[2], b=[7] → `rsp_data` = 14 while `mac_result` = 53, which confirms the base subtraction.
- req0 and req1 both assert `req_valid` in the first cycle after reset → req0 is served first and req1 next. A second simultaneous round serves req0 first again, since `ptr` = 1 after serving req1.
- `rsp_ready` held low for 5 cycles → `rsp_valid`/`rsp_data` stay stable, every `req_ready` stays 0, and `mac_valid_in` stays 0.
- Job a=[0xFFFF,0xFFFF], b=[0xFFFF,0xFFFF] after a prior job with result 39 → `rsp_data` = 0xFFFC0002, which exercises modulo-2^32 wrap of both the sum and the subtraction.
- Assert `reset` after the second beat of a 4-beat job → all outputs go to 0 and no response is produced. A following 1-beat job of 5×5 → `rsp_data` = 25.
